// File: rtl/prng_pkg.sv
// Shared constants, FSM encoding and the single-step LFSR helper used by the
// multi-channel pseudo-random generator.
package prng_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [31:0] DEFAULT_TAPS32   = 32'h6000D083;
    localparam logic [31:0] DEFAULT_RST_SEED = 32'h02468ACD;
    localparam logic [31:0] DEFAULT_SALT     = 32'h9E3779B9;

    typedef enum logic [1:0] {StIdle, StWarmup, StRun} prng_state_e;

    // State and taps arrive zero-extended to MAX_W; the feedback bit lands at width-1.
    function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int unsigned      width);
        logic             fb;
        logic [MAX_W-1:0] fb_vec;
        fb     = ^(state & taps);
        fb_vec = {{(MAX_W-1){1'b0}}, fb};
        return (state >> 1) | (fb_vec << (width - 1));
    endfunction

endpackage

// File: rtl/prng_lfsr_chan.sv
// One Fibonacci LFSR channel: state register, STEP-unrolled next state,
// load/advance muxing and zero-state guard.
module prng_lfsr_chan
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      STEP     = 1,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS32),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(DEFAULT_RST_SEED),
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(DEFAULT_RST_SEED)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d, stepped;

    always_comb begin
        logic [MAX_W-1:0] s;
        s = MAX_W'(state_q);
        for (int unsigned k = 0; k < STEP; k++) begin
            s = lfsr_step(s, MAX_W'(TAPS), WIDTH);
        end
        stepped = s[WIDTH-1:0];
    end

    // A zero seed or a zero state would lock the LFSR forever; substitute RST_SEED.
    always_comb begin
        state_d  = state_q;
        lockup_o = 1'b0;
        if (load_i) begin
            if (load_val_i == '0) begin
                state_d  = RST_SEED;
                lockup_o = 1'b1;
            end else begin
                state_d = load_val_i;
            end
        end else if (adv_i) begin
            if (state_q == '0) begin
                state_d  = RST_SEED;
                lockup_o = 1'b1;
            end else begin
                state_d = stepped;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/prng_lfsr_multi.sv
// Multi-channel LFSR generator: warm-up FSM, per-channel seed derivation,
// sticky lockup flag and a valid/ready output stream.
module prng_lfsr_multi
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      NCH        = 4,
    parameter int unsigned      STEP       = 1,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS32),
    parameter logic [WIDTH-1:0] RST_SEED   = WIDTH'(DEFAULT_RST_SEED),
    parameter logic [WIDTH-1:0] SALT       = WIDTH'(DEFAULT_SALT),
    parameter int unsigned      WARMUP_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable_i,
    input  logic                 seed_load_i,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic                 err_clr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NCH*WIDTH-1:0] out_data_o,
    output logic                 busy_o,
    output logic                 lockup_err_o
);

    localparam int unsigned   CW         = $clog2(WARMUP_CYC + 2);
    localparam logic [CW-1:0] WarmupLoad = CW'(WARMUP_CYC);

    prng_state_e   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          adv, fire;
    logic          err_q, err_d;
    logic [NCH-1:0] lockup;

    assign fire = out_valid_o & out_ready_i;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        localparam logic [WIDTH-1:0] ChSalt = WIDTH'(SALT * WIDTH'(i));

        prng_lfsr_chan #(
            .WIDTH   (WIDTH),
            .STEP    (STEP),
            .TAPS    (TAPS),
            .RST_SEED(RST_SEED),
            .INIT_VAL(RST_SEED ^ ChSalt)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .load_i    (seed_load_i),
            .load_val_i(seed_i ^ ChSalt),
            .adv_i     (adv),
            .state_o   (out_data_o[i*WIDTH +: WIDTH]),
            .lockup_o  (lockup[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q  <= StIdle;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // seed_load overrides everything, including an advance from a beat firing now.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        adv   = 1'b0;
        if (seed_load_i) begin
            st_d  = enable_i ? StWarmup : StIdle;
            cnt_d = WarmupLoad;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (enable_i) begin
                        st_d  = StWarmup;
                        cnt_d = WarmupLoad;
                    end
                end
                StWarmup: begin
                    if (cnt_q == '0) begin
                        st_d = StRun;
                    end else begin
                        adv   = 1'b1;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            st_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (fire) begin
                        adv = 1'b1;
                        if (!enable_i) begin
                            st_d = StIdle;
                        end
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    assign err_d = (|lockup) | (err_q & ~err_clr_i);

    always_comb begin
        out_valid_o  = (st_q == StRun);
        busy_o       = (st_q == StWarmup);
        lockup_err_o = err_q;
    end

endmodule
